// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory port between instruction
// fetch and data load/store, with wait-state support and stall timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic        instr_done,
    output logic [31:0] instr_readdata,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic        data_done,
    output logic [31:0] data_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    state_t             state;
    logic               last_d;
    logic [CNT_W-1:0]   stall_cnt;
    logic               serving;
    logic               stall_limit;
    logic               svc_end;

    assign serving     = (state == SERVE_I) || (state == SERVE_D);
    assign stall_limit = (stall_cnt == CNT_W'(TIMEOUT - 1));
    // Access ends either on a completed handshake or on the last allowed stall cycle.
    assign svc_end     = serving && (!mem_waitrequest || stall_limit);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_d         <= 1'b0;
            stall_cnt      <= '0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            instr_done     <= 1'b0;
            data_done      <= 1'b0;
            instr_readdata <= '0;
            data_readdata  <= '0;
            timeout_err    <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            data_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req && (!instr_req || !last_d)) begin
                        mem_address    <= data_address;
                        mem_byteenable <= data_byteenable;
                        mem_writedata  <= data_writedata;
                        mem_read       <= !data_write;
                        mem_write      <= data_write;
                        last_d         <= 1'b1;
                        stall_cnt      <= '0;
                        state          <= SERVE_D;
                    end else if (instr_req) begin
                        mem_address    <= instr_address;
                        mem_byteenable <= 4'b1111;
                        mem_writedata  <= '0;
                        mem_read       <= 1'b1;
                        mem_write      <= 1'b0;
                        last_d         <= 1'b0;
                        stall_cnt      <= '0;
                        state          <= SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (svc_end) begin
                        if (mem_waitrequest) begin
                            timeout_err <= 1'b1;
                            if (state == SERVE_I) instr_readdata <= '1;
                            else                  data_readdata  <= '1;
                        end else if (state == SERVE_I) begin
                            instr_readdata <= mem_readdata;
                        end else if (!mem_write) begin
                            data_readdata <= mem_readdata;
                        end
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        instr_done <= (state == SERVE_I);
                        data_done  <= (state == SERVE_D);
                        state      <= RESP;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req, data_req, data_write, mem_waitrequest;
    logic [31:0] instr_address, data_address, data_writedata, mem_readdata;
    logic [3:0]  data_byteenable;
    logic        instr_done, data_done, mem_read, mem_write, busy, timeout_err;
    logic [31:0] instr_readdata, data_readdata, mem_address, mem_writedata;
    logic [3:0]  mem_byteenable;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_address(instr_address),
        .instr_done(instr_done), .instr_readdata(instr_readdata),
        .data_req(data_req), .data_write(data_write), .data_address(data_address),
        .data_byteenable(data_byteenable), .data_writedata(data_writedata),
        .data_done(data_done), .data_readdata(data_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_req = 0; data_req = 0; data_write = 0; mem_waitrequest = 0;
        instr_address = 0; data_address = 0; data_writedata = 0; mem_readdata = 0;
        data_byteenable = 0;
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_rd", mem_read, 0);
        chk("rst_wr", mem_write, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_be", mem_byteenable, 0);
        chk("rst_dones", {instr_done, data_done}, 0);
        chk("rst_ird", instr_readdata, 0);
        chk("rst_drd", data_readdata, 0);
        chk("rst_terr", timeout_err, 0);
        reset = 1'b0;
        step();

        // single fetch, zero wait
        instr_address = 32'hBFC00000; instr_req = 1; mem_readdata = 32'h24020005;
        step();
        chk("f_rd", mem_read, 1);
        chk("f_wr", mem_write, 0);
        chk("f_addr", mem_address, 32'hBFC00000);
        chk("f_be", mem_byteenable, 4'hF);
        chk("f_busy", busy, 1);
        step();
        chk("f_done", instr_done, 1);
        chk("f_ddone", data_done, 0);
        chk("f_data", instr_readdata, 32'h24020005);
        chk("f_rd_off", mem_read, 0);
        instr_req = 0;
        step();
        chk("f_idle", busy, 0);
        chk("f_done_off", instr_done, 0);

        // store with 3 wait states
        data_req = 1; data_write = 1; data_address = 32'h1000;
        data_byteenable = 4'b0011; data_writedata = 32'hDEADBEEF;
        mem_waitrequest = 1; mem_readdata = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s_wr", mem_write, 1);
            chk("s_rd", mem_read, 0);
            chk("s_addr", mem_address, 32'h1000);
            chk("s_be", mem_byteenable, 4'b0011);
            chk("s_wd", mem_writedata, 32'hDEADBEEF);
            chk("s_nodone", data_done, 0);
            if (k == 3) mem_waitrequest = 0;
        end
        step();
        chk("s_done", data_done, 1);
        chk("s_wr_off", mem_write, 0);
        chk("s_rdata", data_readdata, 0);
        chk("s_terr", timeout_err, 0);
        data_req = 0; data_write = 0;
        step();
        chk("s_idle", busy, 0);

        // input change during SERVE_I
        instr_req = 1; instr_address = 32'h00400000; mem_waitrequest = 1;
        step();
        chk("c_addr0", mem_address, 32'h00400000);
        instr_address = 32'hDEAD0000; data_address = 32'hCAFE0000;
        step();
        chk("c_addr1", mem_address, 32'h00400000);
        chk("c_be", mem_byteenable, 4'hF);
        chk("c_wd", mem_writedata, 0);
        mem_readdata = 32'h11112222; mem_waitrequest = 0;
        step();
        chk("c_done", instr_done, 1);
        chk("c_data", instr_readdata, 32'h11112222);
        chk("c_addr2", mem_address, 32'h00400000);
        instr_req = 0; instr_address = 0;
        step();

        // timeout on a load
        data_req = 1; data_write = 0; data_address = 32'h2000; data_byteenable = 4'hF;
        mem_waitrequest = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t_rd", mem_read, 1);
            chk("t_terr0", timeout_err, 0);
        end
        step();
        chk("t_rd_off", mem_read, 0);
        chk("t_done", data_done, 1);
        chk("t_data", data_readdata, 32'hFFFFFFFF);
        chk("t_terr1", timeout_err, 1);
        data_req = 0;
        step();
        chk("t_idle", busy, 0);
        chk("t_sticky0", timeout_err, 1);
        data_req = 1; mem_waitrequest = 0; mem_readdata = 32'h0A0B0C0D;
        step();
        chk("g_rd", mem_read, 1);
        step();
        chk("g_done", data_done, 1);
        chk("g_data", data_readdata, 32'h0A0B0C0D);
        chk("g_sticky", timeout_err, 1);
        data_req = 0;
        step();

        // reset mid-access
        data_req = 1; data_address = 32'h3000; mem_waitrequest = 1;
        step();
        chk("r_rd_on", mem_read, 1);
        reset = 1'b1;
        #1;
        chk("r_rd_async", mem_read, 0);
        chk("r_wr_async", mem_write, 0);
        chk("r_busy", busy, 0);
        chk("r_terr", timeout_err, 0);
        chk("r_done", {instr_done, data_done}, 0);
        data_req = 0;
        step();
        chk("r_hold_done", {instr_done, data_done}, 0);
        reset = 1'b0;

        // contention after reset: D, I, D, I
        instr_address = 32'h100; data_address = 32'h200; data_write = 0;
        mem_waitrequest = 0; mem_readdata = 32'h55AA55AA;
        instr_req = 1; data_req = 1;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("x_addr", mem_address, (g % 2 == 0) ? 32'h200 : 32'h100);
            chk("x_rd", mem_read, 1);
            chk("x_nodone", {instr_done, data_done}, 0);
            step();
            chk("x_done", {instr_done, data_done}, (g % 2 == 0) ? 2'b01 : 2'b10);
            chk("x_strb", {mem_read, mem_write}, 0);
            step();
            chk("x_idle", busy, 0);
        end
        instr_req = 0; data_req = 0;
        chk("x_ird", instr_readdata, 32'h55AA55AA);
        chk("x_drd", data_readdata, 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
